// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised dual-port scratchpad RAM.
// be_merge works on a wide fixed vector; callers zero-extend and truncate to their width.
package ram_pkg;

    typedef enum logic {
        RAM_IDLE  = 1'b0,
        RAM_CLEAR = 1'b1
    } ram_state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    localparam int BE_MERGE_MAX_W = 512;

    function automatic logic [BE_MERGE_MAX_W-1:0] be_merge(
        input logic [BE_MERGE_MAX_W-1:0]   old_w,
        input logic [BE_MERGE_MAX_W-1:0]   new_w,
        input logic [BE_MERGE_MAX_W/8-1:0] be
    );
        logic [BE_MERGE_MAX_W-1:0] res;
        res = old_w;
        for (int i = 0; i < BE_MERGE_MAX_W/8; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Data+valid delay line of STAGES registers; each stage keeps its last data value
// when no valid word passes through it.
module ram_rd_pipe #(
    parameter int DATA_W = 16,
    parameter int STAGES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic              v_q;
        logic [DATA_W-1:0] d_q;
        logic              v_d;
        logic [DATA_W-1:0] d_src;

        if (gi == 0) begin : g_first
            assign v_d   = in_valid;
            assign d_src = in_data;
        end else begin : g_next
            assign v_d   = g_stage[gi-1].v_q;
            assign d_src = g_stage[gi-1].d_q;
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                v_q <= 1'b0;
                d_q <= '0;
            end else begin
                v_q <= v_d;
                if (v_d) begin
                    d_q <= d_src;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign out_data  = g_stage[STAGES-1].d_q;

endmodule

// File: rtl/ram_dp_param.sv
// Simple-dual-port scratchpad RAM with byte enables, 1/2-cycle read latency,
// selectable read-during-write result and a one-word-per-cycle hardware clear.
module ram_dp_param
    import ram_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 11,
    parameter int DEPTH          = 2**ADDR_W,
    parameter int RD_LAT         = 1,
    parameter int RDW_MODE       = RDW_OLD,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear_req,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  busy
);

    localparam int               BE_W        = DATA_W / 8;
    localparam logic [ADDR_W:0]  DEPTH_L     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]  LAST_L      = (ADDR_W+1)'(DEPTH - 1);
    localparam ram_state_e       RESET_STATE = (CLEAR_ON_RESET != 0) ? RAM_CLEAR : RAM_IDLE;

    ram_state_e        state_q, state_d;
    logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RESET_STATE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            RAM_IDLE: begin
                if (clear_req) begin
                    state_d   = RAM_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            RAM_CLEAR: begin
                if (clr_cnt_q == LAST_L) begin
                    state_d   = RAM_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + (ADDR_W+1)'(1);
                end
            end
            default: begin
                state_d   = RAM_IDLE;
                clr_cnt_d = '0;
            end
        endcase
    end

    assign busy = (state_q == RAM_CLEAR);

    logic              wr_in_range, rd_in_range;
    logic              wr_fire, rd_fire;
    logic [ADDR_W-1:0] rd_idx;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
    assign wr_fire     = wr_en && !busy && wr_in_range;
    assign rd_fire     = rd_en && !busy;
    assign rd_idx      = rd_in_range ? rd_addr : '0;

    // The clear FSM borrows the write port; reset itself never writes the array.
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_wbe;

    assign mem_waddr = busy ? clr_cnt_q[ADDR_W-1:0] : wr_addr;
    assign mem_wdata = busy ? '0 : wr_data;

    for (genvar gi = 0; gi < BE_W; gi++) begin : g_wbe
        assign mem_wbe[gi] = !reset && (busy || (wr_fire && wr_be[gi]));
    end

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        for (int b = 0; b < BE_W; b++) begin
            if (mem_wbe[b]) begin
                mem_q[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // First read stage: registered array output plus what is needed to patch it afterwards.
    logic [DATA_W-1:0] rd_raw_q;
    logic              rd_valid_q;
    logic              rd_oob_q;
    logic              rd_hit_q;
    logic [DATA_W-1:0] rd_wdata_q;
    logic [BE_W-1:0]   rd_wbe_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_raw_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_oob_q   <= 1'b0;
            rd_hit_q   <= 1'b0;
            rd_wdata_q <= '0;
            rd_wbe_q   <= '0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_raw_q   <= mem_q[rd_idx];
                rd_oob_q   <= !rd_in_range;
                rd_hit_q   <= wr_fire && (wr_addr == rd_addr) && (RDW_MODE == RDW_NEW);
                rd_wdata_q <= wr_data;
                rd_wbe_q   <= wr_be;
            end
        end
    end

    logic [DATA_W-1:0] rd_word;

    always_comb begin
        rd_word = rd_raw_q;
        if (rd_oob_q) begin
            rd_word = '0;
        end else if (rd_hit_q) begin
            rd_word = DATA_W'(be_merge(BE_MERGE_MAX_W'(rd_raw_q),
                                       BE_MERGE_MAX_W'(rd_wdata_q),
                                       (BE_MERGE_MAX_W/8)'(rd_wbe_q)));
        end
    end

    if (RD_LAT <= 1) begin : g_lat1
        assign rd_data  = rd_word;
        assign rd_valid = rd_valid_q;
    end else begin : g_latn
        ram_rd_pipe #(
            .DATA_W (DATA_W),
            .STAGES (RD_LAT - 1)
        ) u_rd_pipe (
            .clock     (clock),
            .reset     (reset),
            .in_valid  (rd_valid_q),
            .in_data   (rd_word),
            .out_valid (rd_valid),
            .out_data  (rd_data)
        );
    end

endmodule

// File: tb/tb_ram_dp_param.sv
// Scoreboard bench driving three RAM variants in lockstep:
// d0 = RD_LAT 1 / old-data, d1 = RD_LAT 2 / new-data, d2 = RD_LAT 2 / old-data / DEPTH 1000.
module tb_ram_dp_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_req;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        rd_en;
    logic [10:0] rd_addr;
    logic [15:0] rd_data  [3];
    logic        rd_valid [3];
    logic        busy     [3];

    always #5 clk = ~clk;

    ram_dp_param #(.DATA_W(16), .ADDR_W(11), .DEPTH(2048), .RD_LAT(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_d0 (
        .clock(clk), .reset(reset), .clear_req(clear_req),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .busy(busy[0]));

    ram_dp_param #(.DATA_W(16), .ADDR_W(11), .DEPTH(2048), .RD_LAT(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_d1 (
        .clock(clk), .reset(reset), .clear_req(clear_req),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .busy(busy[1]));

    ram_dp_param #(.DATA_W(16), .ADDR_W(11), .DEPTH(1000), .RD_LAT(2), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_d2 (
        .clock(clk), .reset(reset), .clear_req(clear_req),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data[2]), .rd_valid(rd_valid[2]), .busy(busy[2]));

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic int rdw_of(input int d);
        return (d == 1) ? 1 : 0;
    endfunction

    function automatic int dep_of(input int d);
        return (d == 2) ? 1000 : 2048;
    endfunction

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        exp_q [3][$];
    logic [15:0] mdl   [3][2048];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rd_valid[d] === 1'b1) begin
                if (exp_q[d].size() == 0) begin
                    check_eq($sformatf("spurious_valid_d%0d", d), 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q[d].pop_front();
                    $display("RD d%0d cyc=%0d data=%h exp=%h due=%0d", d, cyc, rd_data[d], e.data, e.due);
                    check_eq($sformatf("rd_data_d%0d", d), 32'(rd_data[d]), 32'(e.data));
                    check_eq($sformatf("rd_lat_d%0d", d), 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_zero();
        for (int d = 0; d < 3; d++)
            for (int a = 0; a < 2048; a++)
                mdl[d][a] = 16'h0000;
    endtask

    // One user cycle: predict every variant's read result, update the models, then clock.
    task automatic op(input logic we, input logic [10:0] wa, input logic [15:0] wd,
                      input logic [1:0] be, input logic re, input logic [10:0] ra);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra; clear_req = 1'b0;
        if (re) begin
            for (int d = 0; d < 3; d++) begin
                exp_t        e;
                logic [15:0] w;
                w = (int'(ra) < dep_of(d)) ? mdl[d][ra] : 16'h0000;
                if (we && be != 2'b00 && wa == ra && int'(wa) < dep_of(d) && rdw_of(d) == 1) begin
                    for (int b = 0; b < 2; b++)
                        if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
                end
                e.data = w;
                e.due  = cyc + lat_of(d);
                exp_q[d].push_back(e);
            end
        end
        if (we) begin
            for (int d = 0; d < 3; d++) begin
                if (int'(wa) < dep_of(d)) begin
                    for (int b = 0; b < 2; b++)
                        if (be[b]) mdl[d][wa][8*b +: 8] = wd[8*b +: 8];
                end
            end
        end
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, 11'h0, 16'h0, 2'b00, 1'b0, 11'h0);
    endtask

    task automatic rd(input logic [10:0] a);
        op(1'b0, 11'h0, 16'h0, 2'b00, 1'b1, a);
    endtask

    task automatic wr(input logic [10:0] a, input logic [15:0] v, input logic [1:0] be);
        op(1'b1, a, v, be, 1'b0, 11'h0);
    endtask

    // Counts post-edge samples with busy high, starting from the current one.
    task automatic count_busy(input string tag, input bit poke);
        int cnt [3];
        int guard;
        bit any;
        for (int d = 0; d < 3; d++) cnt[d] = 0;
        for (guard = 0; guard < 5000; guard++) begin
            any = 1'b0;
            for (int d = 0; d < 3; d++) begin
                if (busy[d] === 1'b1) begin
                    cnt[d]++;
                    any = 1'b1;
                end
            end
            if (!any) break;
            rd_en     = poke && (guard < 20);
            rd_addr   = 11'h001;
            clear_req = poke && (guard == 50);
            tick();
        end
        rd_en     = 1'b0;
        clear_req = 1'b0;
        for (int d = 0; d < 3; d++)
            check_eq($sformatf("%s_busy_cycles_d%0d", tag, d), 32'(cnt[d]), 32'(dep_of(d)));
    endtask

    initial begin
        reset = 1'b1; clear_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        wr_be = '0; rd_en = 1'b0; rd_addr = '0;
        repeat (3) tick();
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("reset_rd_data_d%0d", d), 32'(rd_data[d]), 32'h0);
            check_eq($sformatf("reset_rd_valid_d%0d", d), 32'(rd_valid[d]), 32'h0);
            check_eq($sformatf("reset_busy_d%0d", d), 32'(busy[d]), 32'h1);
        end
        reset = 1'b0;
        model_zero();
        count_busy("post_reset", 1'b0);

        // Basic write then back-to-back reads
        wr(11'h001, 16'hABCD, 2'b11);
        wr(11'h002, 16'h1234, 2'b11);
        wr(11'h003, 16'h5678, 2'b11);
        rd(11'h001); rd(11'h002); rd(11'h003);
        idle(3);

        // Byte enables
        wr(11'h010, 16'hFFFF, 2'b11);
        wr(11'h010, 16'h1200, 2'b10);
        rd(11'h010);
        idle(3);

        // Read during write, then a later read
        op(1'b1, 11'h020, 16'hBEEF, 2'b11, 1'b1, 11'h020);
        rd(11'h020);
        idle(3);

        // Range edge for the DEPTH=1000 variant
        wr(11'h7FF, 16'h1111, 2'b11);
        wr(11'h3E7, 16'h4321, 2'b11);
        rd(11'h7FF); rd(11'h3E7);
        op(1'b1, 11'h7FF, 16'h2222, 2'b01, 1'b1, 11'h7FF);
        idle(3);

        // wr_be of zero writes nothing
        op(1'b1, 11'h030, 16'h9999, 2'b00, 1'b0, 11'h0);
        rd(11'h030);
        idle(3);

        // Random traffic on a small window so collisions are frequent
        for (int i = 0; i < 60; i++) begin
            op(1'($urandom_range(0, 1)), 11'($urandom_range(0, 15)), 16'($urandom),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 11'($urandom_range(0, 15)));
        end
        idle(4);

        // Hardware clear; reads and a second clear_req during busy are ignored
        for (int a = 0; a < 16; a++) wr(11'(a), 16'hA5A5, 2'b11);
        idle(3);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        model_zero();
        count_busy("clear_req", 1'b1);
        for (int a = 0; a < 16; a++) rd(11'(a));
        rd(11'h010); rd(11'h020); rd(11'h3E7);
        idle(4);

        // Reset in the middle of a clear restarts it
        wr(11'h005, 16'h7777, 2'b11);
        rd(11'h005);
        idle(3);
        for (int d = 0; d < 3; d++)
            check_eq($sformatf("rd_data_hold_d%0d", d), 32'(rd_data[d]), 32'h7777);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (100) tick();
        reset = 1'b1;
        tick();
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("midreset_rd_data_d%0d", d), 32'(rd_data[d]), 32'h0);
            check_eq($sformatf("midreset_rd_valid_d%0d", d), 32'(rd_valid[d]), 32'h0);
            check_eq($sformatf("midreset_busy_d%0d", d), 32'(busy[d]), 32'h1);
        end
        reset = 1'b0;
        model_zero();
        count_busy("midreset", 1'b0);
        rd(11'h005); rd(11'h3E7);
        idle(4);

        for (int d = 0; d < 3; d++)
            check_eq($sformatf("scoreboard_drained_d%0d", d), 32'(exp_q[d].size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
